// File: rtl/othello_pkg.sv
// Shared Othello board definitions: cell codes, display colours, plotter FSM encoding
// and the default plot geometry.
package othello_pkg;

    typedef logic [1:0] cell_code_t;
    typedef logic [2:0] colour_t;

    localparam cell_code_t CELL_EMPTY0 = 2'd0;
    localparam cell_code_t CELL_EMPTY1 = 2'd1;
    localparam cell_code_t CELL_SIDE0  = 2'd2;
    localparam cell_code_t CELL_SIDE1  = 2'd3;

    localparam colour_t COL_BOARD  = 3'b010;
    localparam colour_t COL_SIDE0  = 3'b000;
    localparam colour_t COL_SIDE1  = 3'b111;
    localparam colour_t COL_CURSOR = 3'b100;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_FETCH = 3'd1;
    localparam logic [2:0] ST_WAIT  = 3'd2;
    localparam logic [2:0] ST_DRAW  = 3'd3;
    localparam logic [2:0] ST_NEXT  = 3'd4;
    localparam logic [2:0] ST_DONE  = 3'd5;

    localparam int CELL_PX_DEF  = 13;
    localparam int SQ_PX_DEF    = 12;
    localparam int ORIGIN_X_DEF = 9;
    localparam int ORIGIN_Y_DEF = 9;

    // Both empty encodings show as bare board.
    function automatic colour_t cell_colour(input cell_code_t code);
        case (code)
            CELL_SIDE0: return COL_SIDE0;
            CELL_SIDE1: return COL_SIDE1;
            default:    return COL_BOARD;
        endcase
    endfunction

endpackage

// File: rtl/board_plotter_if.sv
// Board read port plus VGA pixel bus owned by board_plotter.
// master = plotter side, slave = board RAM / VGA adapter side.
interface board_plotter_if;
    logic [2:0] rd_x;
    logic [2:0] rd_y;
    logic [1:0] rd_q;
    logic [7:0] x_plot;
    logic [6:0] y_plot;
    logic [2:0] colour;
    logic       plot;

    modport master (
        output rd_x, rd_y, x_plot, y_plot, colour, plot,
        input  rd_q
    );

    modport slave (
        input  rd_x, rd_y, x_plot, y_plot, colour, plot,
        output rd_q
    );
endinterface

// File: rtl/pixel_scan.sv
// Raster counter over one SQ_PX x SQ_PX square: px runs fastest, then py.
// Wraps to (0,0) after the last pixel; clear has priority over enable.
module pixel_scan #(
    parameter int SQ_PX = 12
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       en_i,
    input  logic       clr_i,
    output logic [3:0] px_o,
    output logic [3:0] py_o,
    output logic       last_o
);

    localparam logic [3:0] MAX = 4'(SQ_PX - 1);

    logic [3:0] px_q, px_d;
    logic [3:0] py_q, py_d;

    always_comb begin
        px_d = px_q;
        py_d = py_q;
        if (clr_i) begin
            px_d = 4'd0;
            py_d = 4'd0;
        end else if (en_i) begin
            if (px_q == MAX) begin
                px_d = 4'd0;
                py_d = (py_q == MAX) ? 4'd0 : py_q + 4'd1;
            end else begin
                px_d = px_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clock or posedge resetn) begin
        if (resetn) begin
            px_q <= 4'd0;
            py_q <= 4'd0;
        end else begin
            px_q <= px_d;
            py_q <= py_d;
        end
    end

    assign px_o   = px_q;
    assign py_o   = py_q;
    assign last_o = (px_q == MAX) && (py_q == MAX);

endmodule

// File: rtl/board_plotter.sv
// Walks the 8x8 board and streams one filled square per cell to the VGA pixel bus.
// Optional CURSOR_HIGHLIGHT_EN outlines cell (cur_x,cur_y) in red.
module board_plotter
    import othello_pkg::*;
#(
    parameter int CELL_PX  = CELL_PX_DEF,
    parameter int SQ_PX    = SQ_PX_DEF,
    parameter int ORIGIN_X = ORIGIN_X_DEF,
    parameter int ORIGIN_Y = ORIGIN_Y_DEF
) (
    input  logic                   clock,
    input  logic                   resetn,
    input  logic                   start,
    input  logic                   plot_hold,
    input  logic [2:0]             cur_x,
    input  logic [2:0]             cur_y,
    board_plotter_if.master        bus,
    output logic                   busy,
    output logic                   done
);

    logic [2:0] state_q, state_d;
    logic [5:0] cell_q, cell_d;
    logic [2:0] rd_x_q, rd_x_d;
    logic [2:0] rd_y_q, rd_y_d;
    colour_t    cell_col_q, cell_col_d;
    logic [7:0] x_plot_q, x_plot_d;
    logic [6:0] y_plot_q, y_plot_d;
    colour_t    colour_q, colour_d;
    logic       plot_q, plot_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;

    logic [3:0] px, py;
    logic       scan_last;
    logic       scan_en;
    colour_t    pix_col;
    logic [7:0] x_pix;
    logic [6:0] y_pix;

    assign scan_en = (state_q == ST_DRAW) && !plot_hold;

    pixel_scan #(.SQ_PX(SQ_PX)) u_scan (
        .clock  (clock),
        .resetn (resetn),
        .en_i   (scan_en),
        .clr_i  (state_q == ST_FETCH),
        .px_o   (px),
        .py_o   (py),
        .last_o (scan_last)
    );

    assign x_pix = 8'(ORIGIN_X) + 8'(CELL_PX) * {5'd0, rd_x_q} + {4'd0, px};
    assign y_pix = 7'(ORIGIN_Y) + 7'(CELL_PX) * {4'd0, rd_y_q} + {3'd0, py};

`ifdef CURSOR_HIGHLIGHT_EN
    logic on_cursor, on_border;
    assign on_cursor = (rd_x_q == cur_x) && (rd_y_q == cur_y);
    assign on_border = (px == 4'd0) || (px == 4'(SQ_PX - 1)) ||
                       (py == 4'd0) || (py == 4'(SQ_PX - 1));
    assign pix_col   = (on_cursor && on_border) ? COL_CURSOR : cell_col_q;
`else
    logic unused_cursor;
    assign unused_cursor = ^{cur_x, cur_y};
    assign pix_col       = cell_col_q;
`endif

    always_comb begin
        state_d    = state_q;
        cell_d     = cell_q;
        rd_x_d     = rd_x_q;
        rd_y_d     = rd_y_q;
        cell_col_d = cell_col_q;
        x_plot_d   = x_plot_q;
        y_plot_d   = y_plot_q;
        colour_d   = colour_q;
        plot_d     = 1'b0;
        busy_d     = busy_q;
        done_d     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_FETCH;
                    cell_d  = 6'd0;
                    busy_d  = 1'b1;
                end
            end
            ST_FETCH: begin
                rd_x_d  = cell_q[2:0];
                rd_y_d  = cell_q[5:3];
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                cell_col_d = cell_colour(bus.rd_q);
                state_d    = ST_DRAW;
            end
            // A held cycle leaves the registered pixel untouched so it resumes in place.
            ST_DRAW: begin
                if (!plot_hold) begin
                    plot_d   = 1'b1;
                    x_plot_d = x_pix;
                    y_plot_d = y_pix;
                    colour_d = pix_col;
                    if (scan_last)
                        state_d = (cell_q == 6'd63) ? ST_DONE : ST_NEXT;
                end
            end
            ST_NEXT: begin
                cell_d  = cell_q + 6'd1;
                state_d = ST_FETCH;
            end
            ST_DONE: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge resetn) begin
        if (resetn) begin
            state_q    <= ST_IDLE;
            cell_q     <= 6'd0;
            rd_x_q     <= 3'd0;
            rd_y_q     <= 3'd0;
            cell_col_q <= 3'd0;
            x_plot_q   <= 8'd0;
            y_plot_q   <= 7'd0;
            colour_q   <= 3'd0;
            plot_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cell_q     <= cell_d;
            rd_x_q     <= rd_x_d;
            rd_y_q     <= rd_y_d;
            cell_col_q <= cell_col_d;
            x_plot_q   <= x_plot_d;
            y_plot_q   <= y_plot_d;
            colour_q   <= colour_d;
            plot_q     <= plot_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign bus.rd_x   = rd_x_q;
    assign bus.rd_y   = rd_y_q;
    assign bus.x_plot = x_plot_q;
    assign bus.y_plot = y_plot_q;
    assign bus.colour = colour_q;
    assign bus.plot   = plot_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_board_plotter.sv
// Scoreboarded bench for board_plotter: a raster model fills the expected pixel queue,
// a negedge monitor pops and compares every plotted pixel.
module tb_board_plotter;

    logic       clock = 1'b0;
    logic       resetn;
    logic       start;
    logic       plot_hold;
    logic [2:0] cur_x, cur_y;
    logic       busy, done;
    logic [1:0] board [64];

    board_plotter_if bus ();

    assign bus.rd_q = board[{bus.rd_y, bus.rd_x}];

    board_plotter dut (
        .clock     (clock),
        .resetn    (resetn),
        .start     (start),
        .plot_hold (plot_hold),
        .cur_x     (cur_x),
        .cur_y     (cur_y),
        .bus       (bus.master),
        .busy      (busy),
        .done      (done)
    );

    always #5 clock = ~clock;

    typedef struct {
        int x;
        int y;
        int c;
    } pix_t;

    pix_t expQ[$];
    int   nChecks   = 0;
    int   nFail     = 0;
    int   plotCount = 0;

    task automatic checkOutput(input string name, input int actual, input int expected);
        nChecks++;
        if (actual != expected) begin
            nFail++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    function automatic int modelColour(input int code);
        if (code < 2) return 2;
        if (code == 2) return 0;
        return 7;
    endfunction

    // Reference raster: cells row-major, each a 12x12 square on a 13-pixel pitch from (9,9).
    task automatic loadModel();
        pix_t p;
        for (int cy = 0; cy < 8; cy++)
            for (int cx = 0; cx < 8; cx++)
                for (int py = 0; py < 12; py++)
                    for (int px = 0; px < 12; px++) begin
                        p.x = 9 + 13 * cx + px;
                        p.y = 9 + 13 * cy + py;
                        p.c = modelColour(int'(board[cy * 8 + cx]));
`ifdef CURSOR_HIGHLIGHT_EN
                        if (cx == int'(cur_x) && cy == int'(cur_y) &&
                            (px == 0 || px == 11 || py == 0 || py == 11))
                            p.c = 4;
`endif
                        expQ.push_back(p);
                    end
    endtask

    task automatic applyStimulus(input int mode);
        for (int i = 0; i < 64; i++)
            board[i] = (mode == 0) ? 2'd0 : 2'($urandom_range(0, 3));
        if (mode == 0) begin
            board[27] = 2'd2;
            board[36] = 2'd2;
            board[28] = 2'd3;
            board[35] = 2'd3;
            cur_x     = 3'd0;
            cur_y     = 3'd0;
        end else begin
            cur_x = 3'($urandom_range(0, 7));
            cur_y = 3'($urandom_range(0, 7));
        end
        expQ.delete();
        loadModel();
        plotCount = 0;
    endtask

    always @(negedge clock) begin : monitor
        pix_t e;
        if (bus.plot === 1'b1) begin
            plotCount++;
            nChecks++;
            if (expQ.size() == 0) begin
                nFail++;
                $display("[TB] FAIL pixel_unexpected: got (%0d,%0d,%0d), expected none",
                         bus.x_plot, bus.y_plot, bus.colour);
            end else begin
                e = expQ.pop_front();
                if (e.x != int'(bus.x_plot) || e.y != int'(bus.y_plot) || e.c != int'(bus.colour)) begin
                    nFail++;
                    $display("[TB] FAIL pixel: got (%0d,%0d,%0d), expected (%0d,%0d,%0d)",
                             bus.x_plot, bus.y_plot, bus.colour, e.x, e.y, e.c);
                end
            end
        end
    end

    // Cycle numbers count rising edges after the edge that accepts start.
    task automatic runFrame(input int expCycles, input int holdAt, input int holdLen,
                            input bit extraStarts, input bit startAtDone);
        int         cyc;
        int         doneAt;
        int         doneCount;
        logic [7:0] frozenX;
        logic [6:0] frozenY;
        frozenX = '0;
        frozenY = '0;
        @(posedge clock);
        #1 start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        cyc       = 0;
        doneAt    = -1;
        doneCount = 0;
        checkOutput("busy_after_start", int'(busy), 1);
        while (cyc < 12000 && (doneAt < 0 || cyc < doneAt + 4)) begin
            @(posedge clock);
            cyc++;
            #1;
            if (done === 1'b1) begin
                doneCount++;
                if (doneAt < 0) doneAt = cyc;
            end
            if (holdAt > 0 && cyc == holdAt - 1) begin
                frozenX = bus.x_plot;
                frozenY = bus.y_plot;
            end
            if (holdAt > 0 && cyc >= holdAt && cyc < holdAt + holdLen) begin
                checkOutput("hold_plot", int'(bus.plot), 0);
                checkOutput("hold_x", int'(bus.x_plot), int'(frozenX));
                checkOutput("hold_y", int'(bus.y_plot), int'(frozenY));
            end
            plot_hold = (holdAt > 0 && cyc >= holdAt - 1 && cyc < holdAt + holdLen - 1);
            start     = (extraStarts && (cyc % 1500 == 700)) ||
                        (startAtDone && cyc == expCycles - 1);
        end
        start     = 1'b0;
        plot_hold = 1'b0;
        checkOutput("done_seen", int'(doneAt >= 0), 1);
        checkOutput("done_cycle", doneAt, expCycles);
        checkOutput("done_pulses", doneCount, 1);
        checkOutput("busy_after_done", int'(busy), 0);
        checkOutput("plot_count", plotCount, 9216);
        checkOutput("queue_empty", expQ.size(), 0);
    endtask

    task automatic resetMidFrame();
        int doneCount;
        applyStimulus(1);
        @(posedge clock);
        #1 start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        repeat (500) @(posedge clock);
        #1;
        checkOutput("plot_before_reset", int'(bus.plot), 1);
        #2 resetn = 1'b1;
        #1;
        checkOutput("rst_plot", int'(bus.plot), 0);
        checkOutput("rst_busy", int'(busy), 0);
        checkOutput("rst_done", int'(done), 0);
        checkOutput("rst_x_plot", int'(bus.x_plot), 0);
        expQ.delete();
        @(posedge clock);
        #1 resetn = 1'b0;
        doneCount = 0;
        repeat (200) begin
            @(posedge clock);
            #1;
            if (done === 1'b1) doneCount++;
        end
        checkOutput("no_done_after_reset", doneCount, 0);
        checkOutput("idle_busy_after_reset", int'(busy), 0);
    endtask

    initial begin
        resetn    = 1'b1;
        start     = 1'b0;
        plot_hold = 1'b0;
        cur_x     = 3'd0;
        cur_y     = 3'd0;
        for (int i = 0; i < 64; i++) board[i] = 2'd0;
        #12;
        checkOutput("reset_busy", int'(busy), 0);
        checkOutput("reset_done", int'(done), 0);
        checkOutput("reset_plot", int'(bus.plot), 0);
        checkOutput("reset_x_plot", int'(bus.x_plot), 0);
        checkOutput("reset_y_plot", int'(bus.y_plot), 0);
        checkOutput("reset_colour", int'(bus.colour), 0);
        checkOutput("reset_rd_x", int'(bus.rd_x), 0);
        checkOutput("reset_rd_y", int'(bus.rd_y), 0);
        @(posedge clock);
        #1 resetn = 1'b0;

        $display("[TB] frame A: opening position");
        applyStimulus(0);
        runFrame(9408, 0, 0, 1'b0, 1'b0);

        $display("[TB] frame B: random board, hold and extra starts");
        applyStimulus(1);
        runFrame(9418, 1000, 10, 1'b1, 1'b0);

        $display("[TB] reset mid-frame");
        resetMidFrame();

        $display("[TB] frame C: random board, start coinciding with done");
        applyStimulus(1);
        runFrame(9408, 0, 0, 1'b0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
